// File: rtl/alu32_pkg.sv
// Shared widths, FSM state encoding and helpers for the 32-bit shared-adder
// add/sub controller.
package alu32_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } add32_state_t;

  typedef logic req_id_t;

  // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add32_seq_arb_rr2.sv
// Two-requester round-robin arbiter; the pointer names the requester favoured
// on a tie and moves to the loser on every accept.
module arb_rr2 (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr_r;

  // One-hot grant from the request vector and the priority pointer.
  always_comb begin
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_r ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Priority pointer update on accept.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr_r <= 1'b0;
    end else if (accept && (grant != 2'b00)) begin
      ptr_r <= grant[0];
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/cla_adder16.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module cla_adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        c16
);

  // Generate/propagate, per-group lookahead carries and the sum bits.
  always_comb begin
    logic [15:0] g_v;
    logic [15:0] p_v;
    logic [16:0] c_v;
    g_v = a & b;
    p_v = a ^ b;
    c_v = 17'd0;
    c_v[0] = cin;
    for (int k = 0; k < 4; k++) begin
      c_v[4*k+1] = g_v[4*k] | (p_v[4*k] & c_v[4*k]);
      c_v[4*k+2] = g_v[4*k+1] | (p_v[4*k+1] & g_v[4*k])
                 | (p_v[4*k+1] & p_v[4*k] & c_v[4*k]);
      c_v[4*k+3] = g_v[4*k+2] | (p_v[4*k+2] & g_v[4*k+1])
                 | (p_v[4*k+2] & p_v[4*k+1] & g_v[4*k])
                 | (p_v[4*k+2] & p_v[4*k+1] & p_v[4*k] & c_v[4*k]);
      c_v[4*k+4] = g_v[4*k+3] | (p_v[4*k+3] & g_v[4*k+2])
                 | (p_v[4*k+3] & p_v[4*k+2] & g_v[4*k+1])
                 | (p_v[4*k+3] & p_v[4*k+2] & p_v[4*k+1] & g_v[4*k])
                 | (p_v[4*k+3] & p_v[4*k+2] & p_v[4*k+1] & p_v[4*k] & c_v[4*k]);
    end
    sum = p_v ^ c_v[15:0];
    c16 = c_v[16];
  end

endmodule

// File: rtl/add32_seq_ctrl.sv
// 32-bit add/sub controller time-sharing one cla_adder16 between two requesters.
// Optional signed-overflow output is compiled in with ADD32_OVF_EN.
module add32_seq_ctrl
  import alu32_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_sub,
  input  logic [WORD_W-1:0] req_a0,
  input  logic [WORD_W-1:0] req_b0,
  input  logic [WORD_W-1:0] req_a1,
  input  logic [WORD_W-1:0] req_b1,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WORD_W-1:0] rsp_sum,
  output logic              rsp_cout
`ifdef ADD32_OVF_EN
  ,
  output logic              rsp_ovf
`endif
);

  add32_state_t       state_r, state_nxt_s;
  logic [1:0]         grant_s;
  logic               accept_s;
  req_id_t            win_id_s;
  logic [WORD_W-1:0]  a_r, b_r, sum_r;
  logic               cin_r, c16_r, cout_r, valid_r;
  req_id_t            id_r;
  logic [HALF_W-1:0]  add_a_s, add_b_s, add_sum_s;
  logic               add_cin_s, add_cout_s;

  assign accept_s = (state_r == IDLE) && (req_valid != 2'b00);
  assign win_id_s = grant_s[1];

  arb_rr2 u_arb (
    .clk    (clk),
    .n_rst  (n_rst),
    .req    (req_valid),
    .accept (accept_s),
    .grant  (grant_s)
  );

  cla_adder16 u_add (
    .a   (add_a_s),
    .b   (add_b_s),
    .cin (add_cin_s),
    .sum (add_sum_s),
    .c16 (add_cout_s)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = LO;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LO:   state_nxt_s = HI;
      HI:   state_nxt_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request accept and adder operand mux per state.
  always_comb begin
    req_ready = 2'b00;
    add_a_s   = a_r[HALF_W-1:0];
    add_b_s   = b_r[HALF_W-1:0];
    add_cin_s = cin_r;
    case (state_r)
      IDLE: req_ready = grant_s & {2{n_rst}};
      LO: begin
        add_a_s   = a_r[HALF_W-1:0];
        add_b_s   = b_r[HALF_W-1:0];
        add_cin_s = cin_r;
      end
      HI: begin
        add_a_s   = a_r[WORD_W-1:HALF_W];
        add_b_s   = b_r[WORD_W-1:HALF_W];
        add_cin_s = c16_r;
      end
      RESP:    req_ready = 2'b00;
      default: req_ready = 2'b00;
    endcase
  end

  // Operand capture, half-word result accumulation and response valid.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_r     <= {WORD_W{1'b0}};
      b_r     <= {WORD_W{1'b0}};
      cin_r   <= 1'b0;
      id_r    <= 1'b0;
      sum_r   <= {WORD_W{1'b0}};
      c16_r   <= 1'b0;
      cout_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // Subtract is folded into an add: invert B here, +1 enters as C0 in LO.
            a_r   <= win_id_s ? req_a1 : req_a0;
            b_r   <= req_sub[win_id_s] ? ~(win_id_s ? req_b1 : req_b0)
                                       :  (win_id_s ? req_b1 : req_b0);
            cin_r <= req_sub[win_id_s];
            id_r  <= win_id_s;
          end
        end
        LO: begin
          sum_r[HALF_W-1:0] <= add_sum_s;
          c16_r             <= add_cout_s;
        end
        HI: begin
          sum_r[WORD_W-1:HALF_W] <= add_sum_s;
          cout_r                 <= add_cout_s;
          valid_r                <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            valid_r <= 1'b0;
          end
        end
        default: valid_r <= 1'b0;
      endcase
    end
  end

`ifdef ADD32_OVF_EN
  logic ovf_r;

  // Signed overflow, taken from the adder MSB during the high half.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf_r <= 1'b0;
    end else if (state_r == HI) begin
      ovf_r <= add_ovf(a_r[WORD_W-1], b_r[WORD_W-1], add_sum_s[HALF_W-1]);
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign rsp_ovf = ovf_r;
`endif

  assign rsp_valid = valid_r;
  assign rsp_id    = id_r;
  assign rsp_sum   = sum_r;
  assign rsp_cout  = cout_r;

endmodule

// File: tb/tb_add32_seq_ctrl.sv
// Directed self-checking bench for add32_seq_ctrl; overflow checks are
// compiled in with ADD32_OVF_EN.
module tb_add32_seq_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [1:0]  req_valid, req_ready, req_sub;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [31:0] rsp_sum;
`ifdef ADD32_OVF_EN
  logic        rsp_ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  add32_seq_ctrl dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sub   (req_sub),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
`ifdef ADD32_OVF_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  // Single-requester issue; returns at the negedge where rsp_valid is first
  // seen, lat = cycles after the accept cycle (-1 if never accepted / no response).
  task automatic issue(input int id, input logic sub, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    int n;
    @(negedge clk);
    req_sub[id] = sub;
    if (id == 0) begin req_a0 = a; req_b0 = b; end
    else begin req_a1 = a; req_b1 = b; end
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (req_ready[id] !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (req_ready[id] !== 1'b1) begin
      req_valid[id] = 1'b0;
      lat = -1;
    end else begin
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      lat = 0;
      while (lat >= 0) begin
        @(negedge clk); lat++;
        if (rsp_valid === 1'b1) break;
        if (lat > 20) lat = -1;
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1; req_sub = 2'b00;
    req_a0 = 32'd1; req_b0 = 32'd1; req_a1 = 32'd1; req_b1 = 32'd1;
    repeat (2) @(negedge clk);
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_sum !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_sum: got %h want 0", rsp_sum); end
    vectors++; if ({rsp_id, rsp_cout} !== 2'b00) begin miscompares++; $display("FAIL reset_id_cout: got %b want 00", {rsp_id, rsp_cout}); end
`ifdef ADD32_OVF_EN
    vectors++; if (rsp_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_ovf: got %b want 0", rsp_ovf); end
`endif
    req_valid = 2'b00;
    n_rst = 1'b1;
    @(negedge clk);
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL idle_req_ready: got %b want 00", req_ready); end
  endtask

  task automatic test_carry();
    int lat;
    issue(0, 1'b0, 32'h0000_FFFF, 32'h0000_0001, lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL carry_latency: got %0d want 3", lat); end
    vectors++; if (rsp_sum !== 32'h0001_0000) begin miscompares++; $display("FAIL carry_sum: got %h want 00010000", rsp_sum); end
    vectors++; if ({rsp_id, rsp_cout} !== 2'b00) begin miscompares++; $display("FAIL carry_id_cout: got %b want 00", {rsp_id, rsp_cout}); end
`ifdef ADD32_OVF_EN
    vectors++; if (rsp_ovf !== 1'b0) begin miscompares++; $display("FAIL carry_ovf: got %b want 0", rsp_ovf); end
`endif
    @(posedge clk);
    issue(0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    vectors++; if (rsp_sum !== 32'h0) begin miscompares++; $display("FAIL wrap_sum: got %h want 00000000", rsp_sum); end
    vectors++; if (rsp_cout !== 1'b1) begin miscompares++; $display("FAIL wrap_cout: got %b want 1", rsp_cout); end
    @(posedge clk);
  endtask

  task automatic test_sub();
    int lat;
    issue(1, 1'b1, 32'd5, 32'd7, lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL sub_latency: got %0d want 3", lat); end
    vectors++; if (rsp_sum !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL sub_borrow_sum: got %h want fffffffe", rsp_sum); end
    vectors++; if ({rsp_id, rsp_cout} !== 2'b10) begin miscompares++; $display("FAIL sub_borrow_id_cout: got %b want 10", {rsp_id, rsp_cout}); end
    @(posedge clk);
    issue(1, 1'b1, 32'd7, 32'd5, lat);
    vectors++; if (rsp_sum !== 32'h0000_0002) begin miscompares++; $display("FAIL sub_sum: got %h want 00000002", rsp_sum); end
    vectors++; if ({rsp_id, rsp_cout} !== 2'b11) begin miscompares++; $display("FAIL sub_id_cout: got %b want 11", {rsp_id, rsp_cout}); end
    @(posedge clk);
  endtask

  task automatic test_fairness();
    logic [1:0]  ids [4];
    logic [31:0] sums [4];
    logic [3:0]  exp_ids;
    int got, cyc;
    exp_ids = 4'b1010;
    @(negedge clk);
    req_a0 = 32'd1;  req_b0 = 32'd2; req_a1 = 32'd10; req_b1 = 32'd3;
    req_sub = 2'b10; req_valid = 2'b11;
    got = 0; cyc = 0;
    while (got < 4 && cyc < 60) begin
      @(negedge clk); cyc++;
      vectors++; if (req_ready === 2'b11) begin miscompares++; $display("FAIL fair_onehot: got %b want at most one bit", req_ready); end
      if (rsp_valid === 1'b1) begin ids[got] = {1'b0, rsp_id}; sums[got] = rsp_sum; got++; end
    end
    req_valid = 2'b00;
    vectors++; if (got !== 4) begin miscompares++; $display("FAIL fair_count: got %0d want 4", got); end
    for (int i = 0; i < got; i++) begin
      vectors++; if (ids[i][0] !== exp_ids[i]) begin miscompares++; $display("FAIL fair_id%0d: got %0d want %0d", i, ids[i][0], exp_ids[i]); end
      vectors++; if (sums[i] !== (exp_ids[i] ? 32'd7 : 32'd3)) begin miscompares++; $display("FAIL fair_sum%0d: got %h want %h", i, sums[i], exp_ids[i] ? 32'd7 : 32'd3); end
    end
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(0, 1'b0, 32'h1234_5678, 32'h1111_1111, lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL bp_latency: got %0d want 3", lat); end
    vectors++; if (rsp_sum !== 32'h2345_6789) begin miscompares++; $display("FAIL bp_sum: got %h want 23456789", rsp_sum); end
    req_a1 = 32'h0000_0100; req_b1 = 32'h0000_0001; req_sub[1] = 1'b1; req_valid = 2'b10;
    #1;
    vectors++; if (req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_ready_resp: got %b want 00", req_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if ({rsp_valid, req_ready} !== 3'b100) begin miscompares++; $display("FAIL bp_hold%0d valid/ready: got %b want 100", i, {rsp_valid, req_ready}); end
      vectors++; if (rsp_sum !== 32'h2345_6789) begin miscompares++; $display("FAIL bp_hold%0d sum: got %h want 23456789", i, rsp_sum); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++; if ({rsp_valid, req_ready} !== 3'b010) begin miscompares++; $display("FAIL bp_accept_after: got %b want 010", {rsp_valid, req_ready}); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (rsp_valid === 1'b1) break;
    end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL bp_next_latency: got %0d want 3", lat); end
    vectors++; if ({rsp_id, rsp_cout, rsp_sum} !== {2'b11, 32'h0000_00FF}) begin miscompares++; $display("FAIL bp_next_result: got %b %b %h want 1 1 000000ff", rsp_id, rsp_cout, rsp_sum); end
    @(posedge clk);
  endtask

  task automatic test_reset_midop();
    int lat;
    @(negedge clk);
    req_a0 = 32'd3; req_b0 = 32'd4; req_sub = 2'b00; req_valid = 2'b01;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rst_pre_ready: got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    vectors++; if ({req_ready, rsp_valid, rsp_id, rsp_cout} !== 5'b00000) begin miscompares++; $display("FAIL rst_mid_ctrl: got %b want 00000", {req_ready, rsp_valid, rsp_id, rsp_cout}); end
    vectors++; if (rsp_sum !== 32'h0) begin miscompares++; $display("FAIL rst_mid_sum: got %h want 00000000", rsp_sum); end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_dropped_rsp%0d: got %b want 0", i, rsp_valid); end
    end
    req_a0 = 32'h20; req_b0 = 32'h22; req_a1 = 32'h55; req_b1 = 32'h1;
    req_sub = 2'b00; req_valid = 2'b11;
    #1;
    vectors++; if (req_ready !== 2'b01) begin miscompares++; $display("FAIL rst_favour0: got %b want 01", req_ready); end
    @(posedge clk); #1;
    req_valid = 2'b00;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (rsp_valid === 1'b1) break;
    end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rst_next_latency: got %0d want 3", lat); end
    vectors++; if ({rsp_id, rsp_sum} !== {1'b0, 32'h42}) begin miscompares++; $display("FAIL rst_next_result: got %b %h want 0 00000042", rsp_id, rsp_sum); end
    @(posedge clk);
  endtask

`ifdef ADD32_OVF_EN
  task automatic test_overflow();
    int lat;
    issue(0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, lat);
    vectors++; if ({rsp_ovf, rsp_cout, rsp_sum} !== {2'b10, 32'h8000_0000}) begin miscompares++; $display("FAIL ovf_add: got %b %b %h want 1 0 80000000", rsp_ovf, rsp_cout, rsp_sum); end
    @(posedge clk);
    issue(1, 1'b1, 32'h8000_0000, 32'h0000_0001, lat);
    vectors++; if ({rsp_ovf, rsp_cout, rsp_sum} !== {2'b11, 32'h7FFF_FFFF}) begin miscompares++; $display("FAIL ovf_sub: got %b %b %h want 1 1 7fffffff", rsp_ovf, rsp_cout, rsp_sum); end
    @(posedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_carry();
    test_sub();
    test_fairness();
    test_backpressure();
    test_reset_midop();
`ifdef ADD32_OVF_EN
    test_overflow();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add32_seq_ctrl.md
# add32_seq_ctrl

Multi-cycle controller that shares one 16-bit carry-lookahead adder (`cla_adder16`) between two requesters to perform 32-bit add/subtract. It arbitrates round-robin between the requesters and runs the low half, then the high half, through the adder, chaining the carry through a register. It returns the result on a valid/ready response channel. It sits in the ALU datapath as the low-area add/sub path.

## Interface
- Parameters: none; widths come from the shared package (`WORD_W` = 32, `HALF_W` = 16).
- Reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock, rising edge.
- `n_rst`  in  1  asynchronous active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i.
- `req_ready`  out  2  per-requester accept; at most one bit high.
- `req_sub`  in  2  per-requester op select: 0 = A+B, 1 = A−B.
- `req_a0`, `req_b0`  in  32  requester 0 operands.
- `req_a1`, `req_b1`  in  32  requester 1 operands.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_id`  out  1  index of the requester that owns the result.
- `rsp_sum`  out  32  result.
- `rsp_cout`  out  1  carry-out of bit 31; for subtract, 1 means no borrow.
- `rsp_ovf`  out  1  signed overflow; present only with `ADD32_OVF_EN`.

## Operation
- FSM states: IDLE → LO → HI → RESP → IDLE.
- **IDLE**
  - If any `req_valid` is high, grant one requester, assert its `req_ready` combinationally in the same cycle, and capture its operands and op.
  - Capture rules: `a_q = A`; `b_q = sub ? ~B : B`; `cin_q = sub`; `id_q` = granted index.
  - Next state is LO.
- **Arbitration**
  - Round-robin with a 1-bit priority pointer; reset value 0, so requester 0 is favoured first.
  - If only one requester is valid, it wins.
  - If both are valid, the requester selected by the pointer wins.
  - On each accept, the pointer moves to the non-granted requester.
- **LO**
  - Adder inputs: `a_q[15:0]`, `b_q[15:0]`, `cin_q`.
  - Register `sum_q[15:0]` and `c16_q` (the adder's C16).
  - Next state is HI.
- **HI**
  - Adder inputs: `a_q[31:16]`, `b_q[31:16]`, `c16_q`.
  - Register `sum_q[31:16]` and `cout_q`.
  - With the macro, also register `ovf_q = (a_q[31] == b_q[31]) && (sum[31] != a_q[31])`, where `sum[31]` is the adder's MSB output.
  - Next state is RESP.
- **RESP**
  - `rsp_valid = 1`; `rsp_*` are driven from the registers.
  - Stay in RESP, with all outputs stable, until `rsp_ready` is high; then go to IDLE.
  - No new request is accepted while in RESP.
- `req_ready` is 0 in every state other than IDLE.
- A requester may drop `req_valid` without being accepted; this has no effect.
- Arithmetic is modulo 2^32. Subtraction is A + ~B + 1, with the +1 supplied as the adder's C0 in LO.
- Reset values:
  - state = IDLE.
  - `req_ready = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_sum = 0`, `rsp_cout = 0`, `rsp_ovf = 0`.
  - Priority pointer = 0.
- Reset asserted mid-operation (LO, HI or RESP) discards the in-flight operation with no response; after reset release the FSM restarts in IDLE.

## Timing
- Request accept in cycle T (`req_valid & req_ready`) gives `rsp_valid` high from the rising edge ending cycle T+2, i.e. visible in cycle T+3. This assumes `rsp_ready` was high.
- Minimum issue interval is 4 cycles, because the next accept can occur in the cycle after the RESP handshake.
- `rsp_*` are registered. `req_ready` is combinational from `req_valid`, state and the pointer. No combinational path exists from `rsp_ready` to `req_ready`.
- The adder sits between registers; the critical path is one `cla_adder16` evaluation plus the operand mux.

## Configuration
- `ADD32_OVF_EN` defined: the `rsp_ovf` port, the `ovf_q` register and the overflow logic are compiled in.
- `ADD32_OVF_EN` undefined: the `rsp_ovf` port and its logic are absent; all other behaviour is identical.

## Structure
- Package `alu32_pkg` holds:
  - `WORD_W` and `HALF_W`;
  - the `add32_state_t` enum (IDLE, LO, HI, RESP);
  - the requester-index typedef `req_id_t`.
- Sub-module `arb_rr2`: a 2-requester round-robin arbiter.
  - Inputs: `req[1:0]`, `accept`.
  - Outputs: one-hot `grant[1:0]`.
  - Owns the priority pointer.
- The datapath instantiates the existing `cla_adder16` once.

## Test plan
- Carry across halves: req0 add 0x0000_FFFF + 0x0000_0001 → `rsp_sum` 0x0001_0000, `rsp_cout` 0, `rsp_id` 0, `rsp_valid` in cycle T+3.
- Subtract with borrow: req1 sub 5 − 7 → `rsp_sum` 0xFFFF_FFFE, `rsp_cout` 0, `rsp_id` 1. Then 7 − 5 → 0x0000_0002, `rsp_cout` 1.
- Fairness: both requesters held valid for 4 operations → `rsp_id` sequence 0,1,0,1; `req_ready` never high for both at once.
- Backpressure: `rsp_ready` held low 5 cycles in RESP → `rsp_valid` and `rsp_sum` stable, `req_ready` stays 0; accept occurs in the cycle after `rsp_ready` rises.
- Overflow (with macro): add 0x7FFF_FFFF + 1 → `rsp_sum` 0x8000_0000, `rsp_ovf` 1. Sub 0x8000_0000 − 1 → `rsp_sum` 0x7FFF_FFFF, `rsp_ovf` 1.
- Reset mid-op: assert `n_rst` during HI → all outputs 0 immediately. After release, no response for the dropped op; the next request is serviced with requester 0 favoured.
